pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB): drives PC hold, IF/ID freeze, and ID/EX and IF/ID flush.
//  Resolves load-use hazards, taken-branch squashes, data-memory wait states and halt drain.
//  Sits beside the stage registers; replaces the tied-off hold/im_rd_en and owns the halted status.
//  Keeps stall, flush and wait cycle counters for performance readback.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles after HLT leaves ID before HALTED (EX, MEM, WB retire)
//  CNT_W         16  width of each performance counter
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  id_rs         in   4      source reg 0 of instruction in ID
//  id_rt         in   4      source reg 1 of instruction in ID
//  id_rs_used    in   1      ID instruction reads id_rs
//  id_rt_used    in   1      ID instruction reads id_rt
//  id_is_hlt     in   1      ID holds HLT opcode
//  ex_is_load    in   1      EX holds LW
//  ex_rd         in   4      destination reg of EX instruction
//  ex_branch     in   1      EX branch/jump resolved taken (from flag_rf/jump)
//  dm_busy       in   1      DM cannot complete MEM access this cycle
//  hold          out  1      freeze PC
//  im_rd_en      out  1      instruction memory read enable
//  ifid_hold     out  1      IF/ID keeps contents
//  ifid_flush    out  1      IF/ID loads NOP (16'h0000)
//  idex_flush    out  1      ID/EX loads NOP (bubble)
//  pipe_freeze   out  1      EX/MEM and MEM/WB keep contents
//  halted        out  1      pipeline drained after HLT
//  stall_cnt     out  CNT_W  load-use bubbles inserted
//  flush_cnt     out  CNT_W  taken-branch squashes
//  wait_cnt      out  CNT_W  dm_busy freeze cycles
// BEHAVIOUR
//  States: RUN, DRAIN, HALTED (2-bit, registered). All control outputs are combinational from state and inputs.
//  Reset (rst=0, async): state=RUN, counters=0, drain counter=0, halted=0. In RUN with no events all controls are 0 and im_rd_en=1.
//  Events are evaluated in RUN in priority order. Only the highest event acts in a cycle.
//   1 WAIT: dm_busy=1
//     - hold, ifid_hold and pipe_freeze asserted; idex_flush=0, so ID/EX is also held (freeze).
//     - im_rd_en=0; wait_cnt+1.
//     - Lower events are re-evaluated when dm_busy drops.
//   2 FLUSH: ex_branch=1
//     - ifid_flush=1 and idex_flush=1; hold=0 so the PC loads the target.
//     - flush_cnt+1. Penalty is exactly 2 bubbles.
//     - Overrides a simultaneous load-use or HLT in ID, because the ID instruction is squashed.
//   3 STALL: ex_is_load & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd))
//     - hold=1, ifid_hold=1, idex_flush=1; stall_cnt+1.
//     - Lasts exactly 1 cycle; on the next cycle the load is in MEM and forwarding covers it.
//     - Register 0 never creates a hazard.
//   4 HLT: id_is_hlt=1
//     - Go to DRAIN, load the drain counter with DRAIN_CYCLES.
//     - hold=1, im_rd_en=0, ifid_flush=1; HLT itself advances to EX.
//  DRAIN
//   - hold=1, im_rd_en=0, ifid_flush=1, idex_flush=1 every cycle.
//   - Counter decrements per cycle but not while dm_busy=1. In that case pipe_freeze=1 and wait_cnt+1.
//   - At 0, go to HALTED.
//   - ex_branch during DRAIN is ignored, because the instruction ahead of HLT already resolved.
//  HALTED
//   - halted=1, hold=1, im_rd_en=0, ifid_flush=1, idex_flush=1, pipe_freeze=1.
//   - Leaves only via reset.
//  Counters saturate at all-ones and do not wrap.
//  Reset mid-stall, mid-drain or mid-wait returns to RUN the same instant; no partial counts are retained.
// TESTING
//  1 LW r3 in EX, ADD reading r3 in ID
//    -> hold=ifid_hold=idex_flush=1 for exactly 1 cycle, stall_cnt=1; the same case with ex_rd=0 gives no stall.
//  2 ex_branch=1 with a load-use hazard also present
//    -> ifid_flush=idex_flush=1, hold=0, flush_cnt=1, stall_cnt unchanged.
//  3 dm_busy high for 4 cycles during a branch
//    -> pipe_freeze=1 for 4 cycles, wait_cnt=4, then the flush fires on cycle 5.
//  4 HLT in ID, DRAIN_CYCLES=3
//    -> halted rises exactly 4 clocks later (1 HLT + 3 drain); im_rd_en=0 from the HLT cycle onward.
//  5 HLT drain with dm_busy=1 for 2 cycles
//    -> halted delayed by 2 cycles; a reset pulse then gives RUN, counters 0, halted=0 without a clock edge.
//  6 stall_cnt preloaded near saturation via 65537 forced stalls
//    -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch squashes, data-memory waits and halt drain.
// Also keeps saturating stall/flush/wait performance counters.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_is_hlt,
    input  logic             ex_is_load,
    input  logic [3:0]       ex_rd,
    input  logic             ex_branch,
    input  logic             dm_busy,
    output logic             hold,
    output logic             im_rd_en,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          stall_inc, flush_inc, wait_inc;
    logic          load_use;

    // Register 0 is hardwired, so a load targeting it never blocks a reader.
    assign load_use = ex_is_load && (ex_rd != 4'd0) &&
                      ((id_rs_used && (id_rs == ex_rd)) ||
                       (id_rt_used && (id_rt == ex_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        hold        = 1'b0;
        im_rd_en    = 1'b1;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        wait_inc    = 1'b0;
        unique case (state)
            RUN: begin
                // Only the highest-priority event acts in a given cycle.
                if (dm_busy) begin
                    hold        = 1'b1;
                    ifid_hold   = 1'b1;
                    pipe_freeze = 1'b1;
                    im_rd_en    = 1'b0;
                    wait_inc    = 1'b1;
                end else if (ex_branch) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    hold       = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (id_is_hlt) begin
                    hold       = 1'b1;
                    im_rd_en   = 1'b0;
                    ifid_flush = 1'b1;
                    state_nxt  = DRAIN;
                    drain_nxt  = DW'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                hold       = 1'b1;
                im_rd_en   = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (dm_busy) begin
                    pipe_freeze = 1'b1;
                    wait_inc    = 1'b1;
                end else if (drain_cnt <= DW'(1)) begin
                    drain_nxt = '0;
                    state_nxt = HALTED;
                end else begin
                    drain_nxt = drain_cnt - DW'(1);
                end
            end
            HALTED: begin
                halted      = 1'b1;
                hold        = 1'b1;
                im_rd_en    = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                pipe_freeze = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (wait_inc  && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, flushes, waits, halt drain, reset and saturation.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        id_rs_used, id_rt_used, id_is_hlt, ex_is_load, ex_branch, dm_busy;
    logic        hold, im_rd_en, ifid_hold, ifid_flush, idex_flush, pipe_freeze, halted;
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_hlt(id_is_hlt), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_branch(ex_branch), .dm_busy(dm_busy),
        .hold(hold), .im_rd_en(im_rd_en), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Control outputs as a group: hold, im_rd_en, ifid_hold, ifid_flush, idex_flush, pipe_freeze, halted.
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {hold, im_rd_en, ifid_hold, ifid_flush, idex_flush, pipe_freeze, halted};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_hlt = 1'b0;
        ex_is_load = 1'b0; ex_branch = 1'b0; dm_busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #12;
        //                hold im ifh iff idf frz hlt
        chk_ctl("reset_ctl", 7'b0_1_0_0_0_0_0);
        chk16("reset_stall", stall_cnt, 16'd0);
        chk16("reset_flush", flush_cnt, 16'd0);
        chk16("reset_wait",  wait_cnt,  16'd0);
        rst = 1'b1;
        step();
        chk_ctl("run_idle", 7'b0_1_0_0_0_0_0);

        // Load-use on rs: one-cycle stall
        set_load_use();
        #1 chk_ctl("lu_stall", 7'b1_1_1_0_1_0_0);
        step();
        chk16("lu_stall_cnt", stall_cnt, 16'd1);
        idle();
        #1 chk_ctl("lu_after", 7'b0_1_0_0_0_0_0);
        // Load to r0 with reader on r0 and rt: no hazard
        ex_is_load = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_rs_used = 1'b1;
        id_rt = 4'd0; id_rt_used = 1'b1;
        #1 chk_ctl("lu_r0", 7'b0_1_0_0_0_0_0);
        step();
        chk16("lu_r0_cnt", stall_cnt, 16'd1);
        // Hazard via rt only
        idle();
        ex_is_load = 1'b1; ex_rd = 4'd7; id_rt = 4'd7; id_rt_used = 1'b1; id_rs = 4'd7;
        #1 chk_ctl("lu_rt", 7'b1_1_1_0_1_0_0);
        step();
        chk16("lu_rt_cnt", stall_cnt, 16'd2);
        // Matching reg but not used: no hazard
        id_rt_used = 1'b0;
        #1 chk_ctl("lu_unused", 7'b0_1_0_0_0_0_0);
        step();
        idle();

        // Branch overrides load-use
        set_load_use();
        ex_branch = 1'b1;
        #1 chk_ctl("br_over_lu", 7'b0_1_0_1_1_0_0);
        step();
        chk16("br_flush_cnt", flush_cnt, 16'd1);
        chk16("br_stall_cnt", stall_cnt, 16'd2);
        idle();

        // dm_busy for 4 cycles during a branch, flush on cycle 5
        ex_branch = 1'b1;
        dm_busy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk_ctl("wait_br", 7'b1_0_1_0_0_1_0);
            step();
        end
        chk16("wait_cnt4", wait_cnt, 16'd4);
        chk16("wait_noflush", flush_cnt, 16'd1);
        dm_busy = 1'b0;
        #1 chk_ctl("wait_then_br", 7'b0_1_0_1_1_0_0);
        step();
        chk16("wait_br_flush", flush_cnt, 16'd2);
        idle();

        // HLT with DRAIN_CYCLES=3: halted 4 clocks later
        id_is_hlt = 1'b1;
        #1 chk_ctl("hlt_id", 7'b1_0_0_1_0_0_0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) ex_branch = 1'b1;
            #1 chk_ctl("drain", 7'b1_0_0_1_1_0_0);
            step();
        end
        chk_ctl("halted4", 7'b1_0_0_1_1_1_1);
        chk16("drain_br_ignored", flush_cnt, 16'd2);
        idle();
        set_load_use();
        step();
        chk_ctl("halted_stays", 7'b1_0_0_1_1_1_1);
        chk16("halted_nostall", stall_cnt, 16'd2);
        idle();

        // Asynchronous reset from HALTED
        #2 rst = 1'b0;
        #1 chk_ctl("rst_halt_ctl", 7'b0_1_0_0_0_0_0);
        chk16("rst_halt_stall", stall_cnt, 16'd0);
        chk16("rst_halt_flush", flush_cnt, 16'd0);
        chk16("rst_halt_wait",  wait_cnt,  16'd0);
        step();
        rst = 1'b1;
        step();

        // HLT drain with dm_busy for the first 2 drain cycles: halted after 6 clocks
        id_is_hlt = 1'b1;
        step();
        idle();
        dm_busy = 1'b1;
        #1 chk_ctl("drain_busy", 7'b1_0_0_1_1_1_0);
        step();
        step();
        dm_busy = 1'b0;
        chk16("drain_wait2", wait_cnt, 16'd2);
        step();
        step();
        chk1("drain_not_yet", halted, 1'b0);
        step();
        chk1("drain_halted6", halted, 1'b1);

        // Reset pulse away from any clock edge
        #2 rst = 1'b0;
        #1 chk_ctl("rst_pulse_ctl", 7'b0_1_0_0_0_0_0);
        chk16("rst_pulse_wait", wait_cnt, 16'd0);
        #1 rst = 1'b1;
        step();

        // Saturation after 65537 stalls
        set_load_use();
        repeat (65534) step();
        chk16("sat_fffe", stall_cnt, 16'hFFFE);
        repeat (3) step();
        chk16("sat_ffff", stall_cnt, 16'hFFFF);
        chk16("sat_flush0", flush_cnt, 16'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
